pipeline_trace_buffer: RTL and testbench

PIPELINE_TRACE_BUFFER -- requirements
Module: pipeline_trace_buffer

---
 rtl/pipeline_trace_buffer.sv | 169 ++++++++++++++++
 tb/tb_pipeline_trace_buffer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_trace_buffer.sv
// pipeline_trace_buffer
//   Captures a free-running probe word into a circular buffer. After arm, the
//   buffer records every valid probe sample. When a trigger arrives, it keeps
//   recording for post_cnt more samples and then stops. The captured window
//   is then read out oldest-first, one word per rd_req.
//
// Ports
//   clk        in   1     clock, rising edge
//   rst        in   1     asynchronous reset, active low
//   arm        in   1     start a new capture (clears buffer bookkeeping)
//   trig       in   1     trigger event, qualified by sample_en
//   sample_en  in   1     probe valid this cycle
//   probe      in   W     word to capture
//   post_cnt   in   AW    samples to record after the trigger sample
//   rd_req     in   1     readout request, one word per request
//   rd_data    out  W     readout word (holds value when rd_valid=0)
//   rd_valid   out  1     rd_data valid this cycle
//   rd_last    out  1     final readout word
//   state      out  2     00 IDLE, 01 ARMED, 10 TRIGGERED, 11 DONE
//   count      out  AW+1  valid entries, saturating at D
//   wrapped    out  1     write pointer wrapped since arm
module pipeline_trace_buffer #(
  parameter int W  = 32,
  parameter int D  = 16,
  parameter int AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arm,
  input  logic          trig,
  input  logic          sample_en,
  input  logic [W-1:0]  probe,
  input  logic [AW-1:0] post_cnt,
  input  logic          rd_req,
  output logic [W-1:0]  rd_data,
  output logic          rd_valid,
  output logic          rd_last,
  output logic [1:0]    state,
  output logic [AW:0]   count,
  output logic          wrapped
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ARMED     = 2'b01,
    TRIGGERED = 2'b10,
    DONE      = 2'b11
  } stateT;

  localparam logic [AW:0] FULL = (AW+1)'(D);

  logic [W-1:0] mem [D];

  stateT         stateReg, stateNext;
  logic [AW-1:0] wrPtrReg, wrPtrNext;
  logic [AW:0]   countReg, countNext;
  logic          wrappedReg, wrappedNext;
  logic [AW-1:0] remainingReg, remainingNext;
  logic [AW-1:0] rdPtrReg, rdPtrNext;
  logic [AW:0]   rdCntReg, rdCntNext;
  logic          rdValidReg, rdLastReg, rdLastNext;
  logic [W-1:0]  rdDataReg;
  logic          capture, rdFire, enterDone;

  always_comb begin
    stateNext     = stateReg;
    wrPtrNext     = wrPtrReg;
    countNext     = countReg;
    wrappedNext   = wrappedReg;
    remainingNext = remainingReg;
    rdPtrNext     = rdPtrReg;
    rdCntNext     = rdCntReg;
    capture       = 1'b0;
    rdFire        = 1'b0;
    rdLastNext    = 1'b0;
    enterDone     = 1'b0;

    if (arm) begin
      // arm wins over everything, including a same-cycle trig and capture
      stateNext     = ARMED;
      wrPtrNext     = '0;
      countNext     = '0;
      wrappedNext   = 1'b0;
      remainingNext = '0;
    end else begin
      capture = ((stateReg == ARMED) || (stateReg == TRIGGERED)) && sample_en;
      if (capture) begin
        wrPtrNext = wrPtrReg + 1'b1;
        if (countReg != FULL) countNext = countReg + 1'b1;
        if (wrPtrReg == '1) wrappedNext = 1'b1;
      end

      case (stateReg)
        ARMED: begin
          if (sample_en && trig) begin
            remainingNext = post_cnt;
            if (post_cnt == '0) enterDone = 1'b1;
            else                stateNext = TRIGGERED;
          end
        end
        TRIGGERED: begin
          if (sample_en) begin
            remainingNext = remainingReg - 1'b1;
            if (remainingReg == AW'(1)) enterDone = 1'b1;
          end
        end
        DONE: begin
          // Once every word is delivered (rd_last cycle), fall back to IDLE
          if (rdCntReg == countReg) begin
            stateNext = IDLE;
          end else if (rd_req) begin
            rdFire     = 1'b1;
            rdPtrNext  = rdPtrReg + 1'b1;
            rdCntNext  = rdCntReg + 1'b1;
            rdLastNext = ((rdCntReg + 1'b1) == countReg);
          end
        end
        default: ;
      endcase

      // Oldest entry sits at the write pointer once the buffer has wrapped;
      // use the post-capture pointer/flag since this edge also captures.
      if (enterDone) begin
        stateNext = DONE;
        rdPtrNext = wrappedNext ? wrPtrNext : '0;
        rdCntNext = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg     <= IDLE;
      wrPtrReg     <= '0;
      countReg     <= '0;
      wrappedReg   <= 1'b0;
      remainingReg <= '0;
      rdPtrReg     <= '0;
      rdCntReg     <= '0;
      rdValidReg   <= 1'b0;
      rdLastReg    <= 1'b0;
      rdDataReg    <= '0;
    end else begin
      stateReg     <= stateNext;
      wrPtrReg     <= wrPtrNext;
      countReg     <= countNext;
      wrappedReg   <= wrappedNext;
      remainingReg <= remainingNext;
      rdPtrReg     <= rdPtrNext;
      rdCntReg     <= rdCntNext;
      rdValidReg   <= rdFire;
      rdLastReg    <= rdLastNext;
      if (rdFire) rdDataReg <= mem[rdPtrReg];
    end
  end

  // Buffer contents are deliberately left out of reset
  always_ff @(posedge clk) begin
    if (capture) mem[wrPtrReg] <= probe;
  end

  assign rd_data  = rdDataReg;
  assign rd_valid = rdValidReg;
  assign rd_last  = rdLastReg;
  assign state    = stateReg;
  assign count    = countReg;
  assign wrapped  = wrappedReg;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Directed testbench for pipeline_trace_buffer (W=32, D=16).
module tb_pipeline_trace_buffer;

  localparam int W  = 32;
  localparam int D  = 16;
  localparam int AW = 4;

  logic          clk;
  logic          rst;
  logic          arm;
  logic          trig;
  logic          sampleEn;
  logic [W-1:0]  probe;
  logic [AW-1:0] postCnt;
  logic          rdReq;
  logic [W-1:0]  rdData;
  logic          rdValid;
  logic          rdLast;
  logic [1:0]    state;
  logic [AW:0]   count;
  logic          wrapped;

  int vecCount = 0;
  int errCount = 0;

  pipeline_trace_buffer #(.W(W), .D(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .arm      (arm),
    .trig     (trig),
    .sample_en(sampleEn),
    .probe    (probe),
    .post_cnt (postCnt),
    .rd_req   (rdReq),
    .rd_data  (rdData),
    .rd_valid (rdValid),
    .rd_last  (rdLast),
    .state    (state),
    .count    (count),
    .wrapped  (wrapped)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, settle 1 time unit past it
  task automatic applyCycle(input logic a, input logic t, input logic se,
                            input logic [W-1:0] p, input logic [AW-1:0] pc,
                            input logic rr);
    arm      = a;
    trig     = t;
    sampleEn = se;
    probe    = p;
    postCnt  = pc;
    rdReq    = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyCycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  logic [31:0] expWords [3];

  initial begin
    arm = 0; trig = 0; sampleEn = 0; probe = '0; postCnt = '0; rdReq = 0;
    rst = 1'b0;
    #3;
    checkVal("por_state", 32'(state), 32'd0);
    checkVal("por_count", 32'(count), 32'd0);
    checkVal("por_rdvalid", 32'(rdValid), 32'd0);
    checkVal("por_rddata", rdData, 32'd0);
    #8 rst = 1'b1;
    idleCycle();
    checkVal("idle_hold", 32'(state), 32'd0);

    // Basic capture: probes 1..5, trig on 3, post_cnt=2
    applyCycle(1, 0, 0, '0, '0, 0);
    checkVal("basic_armed", 32'(state), 32'd1);
    for (int p = 1; p <= 5; p++) begin
      applyCycle(0, (p == 3), 1, W'(p), 4'd2, 0);
      if (p == 3) checkVal("basic_trig_state", 32'(state), 32'd2);
    end
    checkVal("basic_done_state", 32'(state), 32'd3);
    checkVal("basic_count", 32'(count), 32'd5);
    checkVal("basic_wrapped", 32'(wrapped), 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyCycle(0, 0, 0, '0, '0, 1);
      checkVal($sformatf("basic_rv%0d", i), 32'(rdValid), 32'd1);
      checkVal($sformatf("basic_rd%0d", i), rdData, 32'(i + 1));
      checkVal($sformatf("basic_last%0d", i), 32'(rdLast), 32'(i == 4));
    end
    applyCycle(0, 0, 0, '0, '0, 1);
    checkVal("basic_after_state", 32'(state), 32'd0);
    checkVal("basic_after_rv", 32'(rdValid), 32'd0);
    checkVal("basic_after_last", 32'(rdLast), 32'd0);
    checkVal("basic_rd_hold", rdData, 32'd5);
    checkVal("basic_count_hold", 32'(count), 32'd5);

    // Wrap: probes 0..19, trig on 19, post_cnt=0
    applyCycle(1, 0, 0, '0, '0, 0);
    for (int p = 0; p < 20; p++) applyCycle(0, (p == 19), 1, W'(p), 4'd0, 0);
    checkVal("wrap_state", 32'(state), 32'd3);
    checkVal("wrap_count", 32'(count), 32'd16);
    checkVal("wrap_wrapped", 32'(wrapped), 32'd1);
    for (int i = 0; i < 16; i++) begin
      applyCycle(0, 0, 0, '0, '0, 1);
      checkVal($sformatf("wrap_rd%0d", i), rdData, 32'(i + 4));
      checkVal($sformatf("wrap_last%0d", i), 32'(rdLast), 32'(i == 15));
    end
    idleCycle();
    checkVal("wrap_idle", 32'(state), 32'd0);
    checkVal("wrap_wrapped_hold", 32'(wrapped), 32'd1);

    // Stall gaps: 10,11,12,13 with sample_en 1,0,1,1; stray trig on the stall
    applyCycle(1, 0, 0, '0, '0, 0);
    applyCycle(0, 0, 1, 32'd10, 4'd0, 0);
    applyCycle(0, 1, 0, 32'd11, 4'd0, 0);
    checkVal("stall_trig_ignored", 32'(state), 32'd1);
    checkVal("stall_count_hold", 32'(count), 32'd1);
    applyCycle(0, 0, 1, 32'd12, 4'd0, 0);
    applyCycle(0, 1, 1, 32'd13, 4'd0, 0);
    checkVal("stall_state", 32'(state), 32'd3);
    checkVal("stall_count", 32'(count), 32'd3);
    expWords[0] = 32'd10; expWords[1] = 32'd12; expWords[2] = 32'd13;
    for (int i = 0; i < 3; i++) begin
      applyCycle(0, 0, 0, '0, '0, 1);
      checkVal($sformatf("stall_rd%0d", i), rdData, expWords[i]);
      checkVal($sformatf("stall_last%0d", i), 32'(rdLast), 32'(i == 2));
    end
    idleCycle();

    // Priority: arm and trig together
    applyCycle(1, 1, 1, 32'hAA, 4'd0, 0);
    checkVal("prio_state", 32'(state), 32'd1);
    checkVal("prio_count", 32'(count), 32'd0);
    applyCycle(0, 0, 0, '0, '0, 1);
    checkVal("prio_rd_ignored", 32'(rdValid), 32'd0);
    checkVal("prio_state_hold", 32'(state), 32'd1);

    // Re-arm mid-readout: probes 100..119, trig on 115, post_cnt=4
    for (int p = 0; p < 20; p++) begin
      applyCycle(0, (p == 15), 1, W'(100 + p), 4'd4, 0);
      if (p == 18) checkVal("rearm_trig_state", 32'(state), 32'd2);
    end
    checkVal("rearm_done", 32'(state), 32'd3);
    checkVal("rearm_count", 32'(count), 32'd16);
    checkVal("rearm_wrapped", 32'(wrapped), 32'd1);
    applyCycle(0, 0, 0, '0, '0, 1);
    checkVal("rearm_rd0", rdData, 32'd104);
    applyCycle(0, 0, 0, '0, '0, 1);
    checkVal("rearm_rd1", rdData, 32'd105);
    applyCycle(1, 0, 0, '0, '0, 0);
    checkVal("rearm_state", 32'(state), 32'd1);
    checkVal("rearm_count0", 32'(count), 32'd0);
    checkVal("rearm_wrapped0", 32'(wrapped), 32'd0);
    checkVal("rearm_rv0", 32'(rdValid), 32'd0);
    applyCycle(0, 0, 0, '0, '0, 1);
    applyCycle(0, 0, 0, '0, '0, 1);
    checkVal("rearm_no_rv", 32'(rdValid), 32'd0);

    // Async reset during TRIGGERED with count=7
    applyCycle(0, 1, 1, 32'd1, 4'd10, 0);
    for (int p = 2; p <= 7; p++) applyCycle(0, 0, 1, W'(p), 4'd0, 0);
    checkVal("rst_pre_state", 32'(state), 32'd2);
    checkVal("rst_pre_count", 32'(count), 32'd7);
    #2 rst = 1'b0;
    #1;
    checkVal("rst_state", 32'(state), 32'd0);
    checkVal("rst_count", 32'(count), 32'd0);
    checkVal("rst_wrapped", 32'(wrapped), 32'd0);
    checkVal("rst_rdvalid", 32'(rdValid), 32'd0);
    #4 rst = 1'b1;
    applyCycle(0, 1, 1, 32'd9, 4'd0, 1);
    applyCycle(0, 1, 1, 32'd9, 4'd0, 1);
    checkVal("rst_stays_idle", 32'(state), 32'd0);
    checkVal("rst_no_capture", 32'(count), 32'd0);
    checkVal("rst_no_rv", 32'(rdValid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
